// File: rtl/avl2ahb.sv
// avl2ahb: Avalon-MM slave to AHB-Lite master bridge.
// Carries one single read or write at a time from an Avalon initiator onto
// the AHB fabric. avl_waitrequest holds the initiator until the AHB data
// phase has finished.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   avl_chipselect     Avalon select
//   avl_address        Avalon word address (AVL_AW bits)
//   avl_read_n         read strobe, active-low
//   avl_write_n        write strobe, active-low
//   avl_byteenable     byte lanes, bit i = data[8i+7:8i]
//   avl_writedata      write data
//   avl_readdata       read data, valid while avl_waitrequest = 0
//   avl_waitrequest    stall, low for exactly one cycle per request
//   HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA   AHB-Lite master outputs
//   HREADY/HRDATA/HRESP                       AHB-Lite master inputs
//   err_sticky         set on AHB ERROR or an illegal request
//   err_clr            clears err_sticky (a same-cycle set wins)
//   dbg_state          current FSM state (0 IDLE, 1 ADDR, 2 DATA, 3 DONE)
//
// Handshake: a request is chipselect with either strobe low. The request
// must stay asserted until the cycle in which avl_waitrequest = 0. That
// cycle completes it and the request is not sampled again.
module avl2ahb #(
    parameter int          AVL_AW     = 16,
    parameter logic [31:0] HADDR_BASE = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              avl_chipselect,
    input  logic [AVL_AW-1:0] avl_address,
    input  logic              avl_read_n,
    input  logic              avl_write_n,
    input  logic [3:0]        avl_byteenable,
    input  logic [31:0]       avl_writedata,
    output logic [31:0]       avl_readdata,
    output logic              avl_waitrequest,
    output logic [31:0]       HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [31:0]       HWDATA,
    input  logic              HREADY,
    input  logic [31:0]       HRDATA,
    input  logic              HRESP,
    output logic              err_sticky,
    input  logic              err_clr,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic        req;
    logic        legal_req;
    logic        be_legal;
    logic [1:0]  be_off;
    logic [2:0]  be_size;
    logic [31:0] word_addr;
    logic        accept;
    logic        reject;
    logic        data_done;

    assign HBURST    = 3'b000;
    assign dbg_state = state;

    assign req       = avl_chipselect & (~avl_read_n | ~avl_write_n);
    assign legal_req = be_legal & ~(~avl_read_n & ~avl_write_n);

    // Big-endian lanes: lane 3 holds byte offset 0.
    always_comb begin
        be_legal = 1'b1;
        be_off   = 2'd0;
        be_size  = 3'd2;
        case (avl_byteenable)
            4'b1111: begin be_off = 2'd0; be_size = 3'd2; end
            4'b1100: begin be_off = 2'd0; be_size = 3'd1; end
            4'b0011: begin be_off = 2'd2; be_size = 3'd1; end
            4'b1000: begin be_off = 2'd0; be_size = 3'd0; end
            4'b0100: begin be_off = 2'd1; be_size = 3'd0; end
            4'b0010: begin be_off = 2'd2; be_size = 3'd0; end
            4'b0001: begin be_off = 2'd3; be_size = 3'd0; end
            default: be_legal = 1'b0;
        endcase
    end

    always_comb begin
        word_addr                = '0;
        word_addr[AVL_AW+1:2]    = avl_address;
    end

    always_comb begin
        state_nxt       = state;
        accept          = 1'b0;
        reject          = 1'b0;
        data_done       = 1'b0;
        HTRANS          = 2'b00;
        avl_waitrequest = 1'b1;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (legal_req) begin
                        accept    = 1'b1;
                        state_nxt = S_ADDR;
                    end else begin
                        // Illegal request: complete at once without touching AHB.
                        reject    = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_ADDR: begin
                HTRANS = 2'b10;
                if (HREADY) state_nxt = S_DATA;
            end
            S_DATA: begin
                // First ERROR cycle arrives with HREADY = 0, so it simply waits.
                if (HREADY) begin
                    data_done = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                avl_waitrequest = 1'b0;
                state_nxt       = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            HADDR        <= '0;
            HWRITE       <= 1'b0;
            HSIZE        <= 3'd2;
            HWDATA       <= '0;
            avl_readdata <= '0;
            err_sticky   <= 1'b0;
        end else begin
            state <= state_nxt;
            // Address-phase signals are captured once and held through
            // ADDR and DATA, so HREADY stalls cannot disturb them.
            if (accept) begin
                HADDR  <= HADDR_BASE | word_addr | {30'd0, be_off};
                HWRITE <= ~avl_write_n;
                HSIZE  <= be_size;
                HWDATA <= avl_writedata;
            end
            if (reject) avl_readdata <= '0;
            else if (data_done && !HWRITE) avl_readdata <= HRDATA;
            if (reject || (data_done && HRESP)) err_sticky <= 1'b1;
            else if (err_clr) err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_avl2ahb.sv
module tb_avl2ahb;

  logic        clk;
  logic        rst;
  logic        avl_chipselect;
  logic [15:0] avl_address;
  logic        avl_read_n;
  logic        avl_write_n;
  logic [3:0]  avl_byteenable;
  logic [31:0] avl_writedata;
  logic [31:0] avl_readdata;
  logic        avl_waitrequest;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        err_sticky;
  logic        err_clr;
  logic [1:0]  dbg_state;

  int n_chk;
  int n_err;

  // {check_readdata, readdata}
  logic [32:0] exp_q[$];
  // {HADDR, HWRITE, HSIZE, HWDATA}
  logic [67:0] ahb_q[$];

  avl2ahb #(.AVL_AW(16), .HADDR_BASE(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .avl_chipselect(avl_chipselect), .avl_address(avl_address),
    .avl_read_n(avl_read_n), .avl_write_n(avl_write_n),
    .avl_byteenable(avl_byteenable), .avl_writedata(avl_writedata),
    .avl_readdata(avl_readdata), .avl_waitrequest(avl_waitrequest),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
    .HRESP(HRESP), .err_sticky(err_sticky), .err_clr(err_clr),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // readdata scoreboard: one entry per Avalon completion
  logic prev_done;
  initial prev_done = 1'b0;
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && !avl_waitrequest) begin
      chk("done_one_cycle", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_completion", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (e[32]) chk("readdata", avl_readdata, e[31:0]);
      end
    end
    prev_done = !rst && !avl_waitrequest;
  end

  // AHB monitor: address phase must match and stay stable while NONSEQ
  logic        in_addr;
  logic        cur_w;
  logic [31:0] cur_wdata;
  initial begin in_addr = 1'b0; cur_w = 1'b0; cur_wdata = '0; end
  always @(negedge clk) begin
    logic [67:0] e;
    if (HTRANS == 2'b10) begin
      if (ahb_q.size() == 0) begin
        chk("unexpected_nonseq", 32'd1, 32'd0);
      end else begin
        e = ahb_q[0];
        chk("haddr", HADDR, e[67:36]);
        chk("hwrite", {31'd0, HWRITE}, {31'd0, e[35]});
        chk("hsize", {29'd0, HSIZE}, {29'd0, e[34:32]});
        chk("hburst", {29'd0, HBURST}, 32'd0);
      end
      in_addr = 1'b1;
    end else if (in_addr) begin
      in_addr = 1'b0;
      if (ahb_q.size() != 0) begin
        e = ahb_q.pop_front();
        cur_w = e[35];
        cur_wdata = e[31:0];
      end
    end
    if (dbg_state == 2'd2 && cur_w) chk("hwdata", HWDATA, cur_wdata);
  end

  // driver: one Avalon transfer plus the AHB slave responses for it
  task automatic xfer(input logic [15:0] addr, input logic [3:0] be,
                      input logic rd, input logic wr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int aw, input int dw,
                      input logic err2, input logic clr, input logic legal,
                      input logic [31:0] exp_haddr, input logic [2:0] exp_hsize,
                      input int exp_cyc);
    int c, a_cnt, d_cnt;
    logic done;
    if (legal) ahb_q.push_back({exp_haddr, wr, exp_hsize, wdata});
    if (!legal) exp_q.push_back({1'b1, 32'd0});
    else if (rd) exp_q.push_back({1'b1, rdata});
    else exp_q.push_back({1'b0, 32'd0});
    @(posedge clk); #1;
    avl_chipselect = 1'b1;
    avl_address = addr;
    avl_byteenable = be;
    avl_read_n = ~rd;
    avl_write_n = ~wr;
    avl_writedata = wdata;
    err_clr = clr;
    HRDATA = rdata;
    c = 0; a_cnt = 0; d_cnt = 0; done = 1'b0;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
      if (c == 2) err_clr = 1'b0;
      if (!avl_waitrequest) begin
        done = 1'b1;
      end else if (HTRANS == 2'b10) begin
        HREADY = (a_cnt >= aw);
        HRESP = 1'b0;
        a_cnt++;
      end else if (dbg_state == 2'd2) begin
        if (err2) begin
          HRESP = 1'b1;
          HREADY = (d_cnt >= 1);
        end else begin
          HRESP = 1'b0;
          HREADY = (d_cnt >= dw);
        end
        d_cnt++;
      end else begin
        HREADY = 1'b1;
        HRESP = 1'b0;
      end
    end
    chk("completed", {31'd0, done}, 32'd1);
    chk("latency", c, exp_cyc);
    @(posedge clk); #1;
    avl_chipselect = 1'b0;
    avl_read_n = 1'b1;
    avl_write_n = 1'b1;
    err_clr = 1'b0;
    HREADY = 1'b1;
    HRESP = 1'b0;
  endtask

  task automatic clear_err();
    @(posedge clk); #1; err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    @(negedge clk);
    chk("err_after_clr", {31'd0, err_sticky}, 32'd0);
  endtask

  initial begin
    int k;
    n_chk = 0; n_err = 0;
    rst = 1'b1;
    avl_chipselect = 1'b0; avl_address = '0; avl_read_n = 1'b1; avl_write_n = 1'b1;
    avl_byteenable = 4'hF; avl_writedata = '0; err_clr = 1'b0;
    HREADY = 1'b1; HRDATA = '0; HRESP = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hwrite", {31'd0, HWRITE}, 32'd0);
    chk("rst_hsize", {29'd0, HSIZE}, 32'd2);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_waitreq", {31'd0, avl_waitrequest}, 32'd1);
    chk("rst_readdata", avl_readdata, 32'd0);
    chk("rst_err", {31'd0, err_sticky}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);

    // word write
    xfer(16'h0040, 4'b1111, 0, 1, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0, 1, 32'h100, 3'd2, 4);
    // byte read, lane 1 -> offset 2
    xfer(16'h0123, 4'b0010, 1, 0, 32'h0, 32'h11223344, 0, 0, 0, 0, 1, 32'h48E, 3'd0, 4);
    @(negedge clk);
    chk("err_clean_read", {31'd0, err_sticky}, 32'd0);
    // remaining lane patterns
    xfer(16'h0005, 4'b1100, 1, 0, 32'h0, 32'hA5A55A5A, 0, 0, 0, 0, 1, 32'h14, 3'd1, 4);
    xfer(16'h0006, 4'b0011, 0, 1, 32'h0000CAFE, 32'h0, 0, 0, 0, 0, 1, 32'h1A, 3'd1, 4);
    xfer(16'h0003, 4'b1000, 1, 0, 32'h0, 32'h01020304, 0, 0, 0, 0, 1, 32'hC, 3'd0, 4);
    xfer(16'h0003, 4'b0100, 1, 0, 32'h0, 32'hF0E0D0C0, 0, 0, 0, 0, 1, 32'hD, 3'd0, 4);
    xfer(16'hFFFF, 4'b0001, 0, 1, 32'h000000AB, 32'h0, 0, 0, 0, 0, 1, 32'h3FFFF, 3'd0, 4);
    // HREADY stalls: 3 in ADDR, 2 in DATA
    xfer(16'h0010, 4'b1111, 1, 0, 32'h0, 32'h55AA00FF, 3, 2, 0, 0, 1, 32'h40, 3'd2, 9);
    // two-cycle AHB ERROR on a write
    xfer(16'h0020, 4'b1111, 0, 1, 32'h12345678, 32'h0, 0, 0, 1, 0, 1, 32'h80, 3'd2, 5);
    @(negedge clk);
    chk("err_after_ahb_err", {31'd0, err_sticky}, 32'd1);
    clear_err();
    // ERROR on a read still returns HRDATA
    xfer(16'h0021, 4'b1111, 1, 0, 32'h0, 32'hBADBAD00, 0, 0, 1, 0, 1, 32'h84, 3'd2, 5);
    @(negedge clk);
    chk("err_after_read_err", {31'd0, err_sticky}, 32'd1);
    clear_err();
    // illegal byteenable with err_clr in the same cycle: set wins
    xfer(16'h0030, 4'b0110, 1, 0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 32'h0, 3'd0, 2);
    @(negedge clk);
    chk("err_set_beats_clr", {31'd0, err_sticky}, 32'd1);
    clear_err();
    // both strobes low
    xfer(16'h0031, 4'b1111, 1, 1, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 3'd0, 2);
    @(negedge clk);
    chk("err_both_strobes", {31'd0, err_sticky}, 32'd1);
    clear_err();

    // reset while in DATA with HREADY low
    ahb_q.push_back({32'h200, 1'b0, 3'd2, 32'h0});
    @(posedge clk); #1;
    avl_chipselect = 1'b1; avl_address = 16'h0080; avl_byteenable = 4'hF;
    avl_read_n = 1'b0; avl_write_n = 1'b1; HREADY = 1'b1;
    k = 0;
    @(negedge clk);
    while (dbg_state != 2'd2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("reached_data", {30'd0, dbg_state}, 32'd2);
    HREADY = 1'b0;
    rst = 1'b1;
    avl_chipselect = 1'b0; avl_read_n = 1'b1;
    @(negedge clk);
    chk("midrst_htrans", {30'd0, HTRANS}, 32'd0);
    chk("midrst_waitreq", {31'd0, avl_waitrequest}, 32'd1);
    chk("midrst_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; HREADY = 1'b1;
    xfer(16'h0081, 4'b1111, 1, 0, 32'h0, 32'h0BADF00D, 0, 0, 0, 0, 1, 32'h204, 3'd2, 4);

    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("ahb_q_drained", ahb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
